cell_memory: RTL and testbench

//   Small register-file data memory: CELL_COUNT byte cells, one synchronous write port, one

---
 rtl/cell_memory_pkg.sv | 11 +
 rtl/cell_memory_if.sv | 28 ++
 rtl/cell_memory_cell.sv | 22 ++
 rtl/cell_memory.sv | 39 +++
 tb/tb_cell_memory.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/cell_memory_pkg.sv
// Shared storage constants and bus types used by the datapath and memory blocks.
// No logic here, so it adds no latency and has no backpressure.
package cell_memory_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/cell_memory_if.sv
// Read/write port bundle for the cell memory; the master drives addresses and write data.
// The read is combinational with zero latency; the bundle has no handshake and no backpressure.
interface cell_memory_if;
  import cell_memory_pkg::*;

  addr_t read_address;
  data_t read_data;
  addr_t write_address;
  data_t write_data;
  logic  write_enable;

  modport master (
    output read_address,
    output write_address,
    output write_data,
    output write_enable,
    input  read_data
  );

  modport slave (
    input  read_address,
    input  write_address,
    input  write_data,
    input  write_enable,
    output read_data
  );

endinterface

// File: rtl/cell_memory_cell.sv
// One storage cell: a DATA_WIDTH register with synchronous clear and a load enable.
// Updates one edge after enable; it always accepts a load, so there is no backpressure.
module memory_cell
  import cell_memory_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  enable,
  input  data_t d,
  output data_t q
);

  // Clear wins over a load issued on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cell_memory.sv
// CELL_COUNT-entry byte register file with one synchronous write port and one combinational read port.
// Writes land on the next edge, reads have zero latency; there is no backpressure.
module cell_memory
  import cell_memory_pkg::*;
#(
  parameter int CELL_COUNT = 4
) (
  input  logic           clock,
  input  logic           reset,
  cell_memory_if.slave   bus
);

  data_t cell_q [CELL_COUNT];
  logic  cell_we [CELL_COUNT];

  // Only in-range addresses can ever match, so out-of-range writes touch no cell.
  for (genvar i = 0; i < CELL_COUNT; i++) begin : g_cell
    assign cell_we[i] = bus.write_enable && (bus.write_address == addr_t'(i));

    memory_cell u_cell (
      .clock  (clock),
      .reset  (reset),
      .enable (cell_we[i]),
      .d      (bus.write_data),
      .q      (cell_q[i])
    );
  end

  // No write-to-read bypass: the mux only ever sees registered contents.
  always_comb begin
    bus.read_data = '0;
    for (int i = 0; i < CELL_COUNT; i++) begin
      if (bus.read_address == addr_t'(i)) begin
        bus.read_data = cell_q[i];
      end
    end
  end

endmodule

// File: tb/tb_cell_memory.sv
// Directed bench for cell_memory; expectations are queued by stimulus and checked by a monitor.
module tb_cell_memory;
  import cell_memory_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  data_t exp_q  [$];
  string name_q [$];
  event  chk_ev;
  data_t model [4];

  cell_memory_if mem_if ();

  cell_memory #(.CELL_COUNT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (mem_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: samples read_data one unit after each request and compares against the queue head.
  initial begin
    data_t exp;
    string nm;
    forever begin
      @(chk_ev);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no expectation queued, read_data=%02h", "scoreboard", mem_if.read_data);
      end else begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        if (mem_if.read_data !== exp) begin
          errors++;
          $display("FAIL %s: addr=%0d read_data=%02h expected=%02h",
                   nm, mem_if.read_address, mem_if.read_data, exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic expect_read(input addr_t addr, input data_t exp, input string nm);
    mem_if.read_address = addr;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    ->chk_ev;
    #2;
  endtask

  task automatic do_write(input addr_t addr, input data_t data, input logic en);
    @(negedge clock);
    mem_if.write_address = addr;
    mem_if.write_data    = data;
    mem_if.write_enable  = en;
    @(posedge clock);
    #1;
    mem_if.write_enable  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_all(input string nm);
    for (int a = 0; a < 4; a++) expect_read(addr_t'(a), model[a], nm);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    mem_if.read_address  = '0;
    mem_if.write_address = '0;
    mem_if.write_data    = '0;
    mem_if.write_enable  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int a = 0; a < 4; a++) model[a] = 8'h00;
    check_all("reset_state");

    // Reset clears everything previously written.
    for (int a = 0; a < 4; a++) begin
      do_write(addr_t'(a), 8'hAA, 1'b1);
      model[a] = 8'hAA;
    end
    check_all("fill_aa");
    pulse_reset();
    for (int a = 0; a < 4; a++) model[a] = 8'h00;
    check_all("reset_clear");

    // Sweep: one write per step, every cell checked after each edge.
    for (int i = 0; i < 1000; i++) begin
      do_write(addr_t'(i % 4), data_t'(i % 256), 1'b1);
      model[i % 4] = data_t'(i % 256);
      check_all("sweep");
    end
    // After the sweep the last writes were i=996..999 -> values 0xE4..0xE7.
    expect_read(8'd0, 8'hE4, "sweep_final0");
    expect_read(8'd3, 8'hE7, "sweep_final3");

    // Write enable low: nothing changes.
    do_write(8'd2, 8'h55, 1'b0);
    expect_read(8'd2, 8'hE6, "enable_low");

    // Read during write to the same address: old value before the edge, new after.
    do_write(8'd1, 8'h10, 1'b1);
    @(negedge clock);
    mem_if.write_address = 8'd1;
    mem_if.write_data    = 8'h20;
    mem_if.write_enable  = 1'b1;
    expect_read(8'd1, 8'h10, "rdw_before_edge");
    @(posedge clock);
    #1;
    mem_if.write_enable = 1'b0;
    expect_read(8'd1, 8'h20, "rdw_after_edge");
    model[1] = 8'h20;

    // Out-of-range write and read.
    do_write(8'd4, 8'h77, 1'b1);
    do_write(8'd255, 8'h77, 1'b1);
    check_all("range_write");
    expect_read(8'd200, 8'h00, "range_read200");
    expect_read(8'd4, 8'h00, "range_read4");

    // Reset beats a simultaneous write; writes resume afterwards.
    @(negedge clock);
    reset = 1'b1;
    mem_if.write_address = 8'd0;
    mem_if.write_data    = 8'hFF;
    mem_if.write_enable  = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem_if.write_enable = 1'b0;
    for (int a = 0; a < 4; a++) model[a] = 8'h00;
    check_all("reset_priority");
    do_write(8'd0, 8'h3C, 1'b1);
    expect_read(8'd0, 8'h3C, "write_after_reset");

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
